// File: rtl/mul_dot_sequencer.sv
// Drives the multiplier/MR unit through an N-term multiply-accumulate over register-file
// operands, with optional SAT MR and MR-to-Rn writeback, and gathers the MV/MN flags.
module mul_dot_sequencer #(
   parameter int RF_DATASIZE = 16,
   parameter int ADDR_W      = 4,
   parameter int CNT_W       = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              seq_start,
   input  logic              seq_abort,
   input  logic [CNT_W-1:0]  seq_len,
   input  logic [ADDR_W-1:0] seq_xaddr,
   input  logic [ADDR_W-1:0] seq_yaddr,
   input  logic [ADDR_W-1:0] seq_xstride,
   input  logic [ADDR_W-1:0] seq_ystride,
   input  logic [3:0]        seq_dtsts,
   input  logic              seq_sub,
   input  logic              seq_sat,
   input  logic              seq_wb,
   input  logic [ADDR_W-1:0] seq_dest,
   input  logic              mul_mv,
   input  logic              mul_mn,
   output logic [ADDR_W-1:0] seq_rf_xaddr,
   output logic [ADDR_W-1:0] seq_rf_yaddr,
   output logic              seq_rf_we,
   output logic [ADDR_W-1:0] seq_rf_waddr,
   output logic              ps_mul_en,
   output logic              ps_mul_otreg,
   output logic [3:0]        ps_mul_dtsts,
   output logic [1:0]        ps_mul_cls,
   output logic [1:0]        ps_mul_sc,
   output logic              seq_busy,
   output logic              seq_done,
   output logic              seq_mv_sticky,
   output logic              seq_mn
);

   if (RF_DATASIZE < 2) begin : g_bad_datasize
      $error("mul_dot_sequencer: RF_DATASIZE must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MAC  = 3'd1,
      S_SAT  = 3'd2,
      S_RDMR = 3'd3,
      S_WBW  = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  k_q, k_d;
   logic [ADDR_W-1:0] xaddr_q, xaddr_d;
   logic [ADDR_W-1:0] yaddr_q, yaddr_d;
   logic [ADDR_W-1:0] xstride_q, xstride_d;
   logic [ADDR_W-1:0] ystride_q, ystride_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [3:0]        dtsts_q, dtsts_d;
   logic              sub_q, sub_d;
   logic              sat_q, sat_d;
   logic              wb_q, wb_d;
   logic              exec_arith_q, exec_arith_d;
   logic              mv_q, mv_d;
   logic              mn_q, mn_d;

   logic              accept_s;
   logic              last_term_s;

   assign accept_s    = (state_q == S_IDLE) && seq_start && !seq_abort;
   assign last_term_s = (k_q == (len_q - {{(CNT_W-1){1'b0}}, 1'b1}));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; abort beats every other transition outside IDLE
   always_comb begin
      state_d = state_q;
      if ((state_q != S_IDLE) && seq_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  state_d = (seq_len == {CNT_W{1'b0}}) ? S_FIN : S_MAC;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_MAC: begin
               if (!last_term_s) begin
                  state_d = S_MAC;
               end else if (sat_q) begin
                  state_d = S_SAT;
               end else if (wb_q) begin
                  state_d = S_RDMR;
               end else begin
                  state_d = S_FIN;
               end
            end
            S_SAT:   state_d = wb_q ? S_RDMR : S_FIN;
            S_RDMR:  state_d = S_WBW;
            S_WBW:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // configuration, term counter, operand addresses and flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q        <= {CNT_W{1'b0}};
         k_q          <= {CNT_W{1'b0}};
         xaddr_q      <= {ADDR_W{1'b0}};
         yaddr_q      <= {ADDR_W{1'b0}};
         xstride_q    <= {ADDR_W{1'b0}};
         ystride_q    <= {ADDR_W{1'b0}};
         dest_q       <= {ADDR_W{1'b0}};
         dtsts_q      <= 4'b0000;
         sub_q        <= 1'b0;
         sat_q        <= 1'b0;
         wb_q         <= 1'b0;
         exec_arith_q <= 1'b0;
         mv_q         <= 1'b0;
         mn_q         <= 1'b0;
      end else begin
         len_q        <= len_d;
         k_q          <= k_d;
         xaddr_q      <= xaddr_d;
         yaddr_q      <= yaddr_d;
         xstride_q    <= xstride_d;
         ystride_q    <= ystride_d;
         dest_q       <= dest_d;
         dtsts_q      <= dtsts_d;
         sub_q        <= sub_d;
         sat_q        <= sat_d;
         wb_q         <= wb_d;
         exec_arith_q <= exec_arith_d;
         mv_q         <= mv_d;
         mn_q         <= mn_d;
      end
   end

   // config is sampled only on an accepted start; addresses advance once per issued term
   always_comb begin
      len_d     = len_q;
      k_d       = k_q;
      xaddr_d   = xaddr_q;
      yaddr_d   = yaddr_q;
      xstride_d = xstride_q;
      ystride_d = ystride_q;
      dest_d    = dest_q;
      dtsts_d   = dtsts_q;
      sub_d     = sub_q;
      sat_d     = sat_q;
      wb_d      = wb_q;
      if (accept_s) begin
         len_d     = seq_len;
         k_d       = {CNT_W{1'b0}};
         xaddr_d   = seq_xaddr;
         yaddr_d   = seq_yaddr;
         xstride_d = seq_xstride;
         ystride_d = seq_ystride;
         dest_d    = seq_dest;
         dtsts_d   = seq_dtsts;
         sub_d     = seq_sub;
         sat_d     = seq_sat;
         wb_d      = seq_wb;
      end else if (state_q == S_MAC) begin
         k_d     = k_q + {{(CNT_W-1){1'b0}}, 1'b1};
         xaddr_d = xaddr_q + xstride_q;
         yaddr_d = yaddr_q + ystride_q;
      end else begin
         k_d = k_q;
      end
   end

   // flags follow the execute cycle of MAC/SAT ops only; RDMR execute leaves them alone
   always_comb begin
      exec_arith_d = (state_q == S_MAC) || (state_q == S_SAT);
      mv_d         = mv_q;
      mn_d         = mn_q;
      if (accept_s) begin
         mv_d = 1'b0;
         mn_d = 1'b0;
      end else if (exec_arith_q) begin
         mv_d = mv_q | mul_mv;
         mn_d = mul_mn;
      end else begin
         mv_d = mv_q;
         mn_d = mn_q;
      end
   end

   assign seq_mv_sticky = mv_q;
   assign seq_mn        = mn_q;

   // multiplier/RF control decode from the registered state
   always_comb begin
      ps_mul_en    = 1'b0;
      ps_mul_otreg = 1'b0;
      ps_mul_dtsts = 4'b0000;
      ps_mul_cls   = 2'b00;
      ps_mul_sc    = 2'b00;
      seq_rf_xaddr = {ADDR_W{1'b0}};
      seq_rf_yaddr = {ADDR_W{1'b0}};
      seq_rf_we    = 1'b0;
      seq_rf_waddr = {ADDR_W{1'b0}};
      seq_busy     = 1'b0;
      seq_done     = 1'b0;
      case (state_q)
         S_MAC: begin
            ps_mul_en    = 1'b1;
            ps_mul_otreg = 1'b1;
            ps_mul_dtsts = dtsts_q;
            if (k_q == {CNT_W{1'b0}}) begin
               ps_mul_cls = 2'b01;
            end else begin
               ps_mul_cls = sub_q ? 2'b11 : 2'b10;
            end
            seq_rf_xaddr = xaddr_q;
            seq_rf_yaddr = yaddr_q;
            seq_busy     = 1'b1;
         end
         S_SAT: begin
            ps_mul_en    = 1'b1;
            ps_mul_otreg = 1'b1;
            ps_mul_dtsts = dtsts_q;
            ps_mul_sc    = 2'b11;
            seq_busy     = 1'b1;
         end
         S_RDMR: begin
            // fractional results live in MR1, integer results in MR0
            ps_mul_en    = 1'b1;
            ps_mul_dtsts = dtsts_q;
            ps_mul_sc    = {1'b0, dtsts_q[1]};
            seq_busy     = 1'b1;
         end
         S_WBW: begin
            seq_rf_we    = 1'b1;
            seq_rf_waddr = dest_q;
            seq_busy     = 1'b1;
         end
         S_FIN: begin
            seq_done = 1'b1;
         end
         default: begin
            seq_busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mul_dot_sequencer.sv
// Randomized self-checking bench for mul_dot_sequencer: a per-cycle expected control
// trace is built from the sequence rules and compared against the DUT every cycle.
module tb_mul_dot_sequencer;

   logic       clk;
   logic       reset;
   logic       seq_start, seq_abort;
   logic [5:0] seq_len;
   logic [3:0] seq_xaddr, seq_yaddr, seq_xstride, seq_ystride, seq_dtsts, seq_dest;
   logic       seq_sub, seq_sat, seq_wb, mul_mv, mul_mn;
   logic [3:0] seq_rf_xaddr, seq_rf_yaddr, seq_rf_waddr, ps_mul_dtsts;
   logic       seq_rf_we, ps_mul_en, ps_mul_otreg, seq_busy, seq_done, seq_mv_sticky, seq_mn;
   logic [1:0] ps_mul_cls, ps_mul_sc;

   typedef struct packed {
      logic       en;
      logic       otreg;
      logic [3:0] dtsts;
      logic [1:0] cls;
      logic [1:0] sc;
      logic [3:0] xa;
      logic [3:0] ya;
      logic       we;
      logic [3:0] wa;
      logic       busy;
      logic       done;
   } ctl_t;

   ctl_t obs;
   int   n_tests = 0;
   int   n_fail  = 0;

   mul_dot_sequencer #(.RF_DATASIZE(16), .ADDR_W(4), .CNT_W(6)) dut (
      .clk(clk), .reset(reset),
      .seq_start(seq_start), .seq_abort(seq_abort), .seq_len(seq_len),
      .seq_xaddr(seq_xaddr), .seq_yaddr(seq_yaddr),
      .seq_xstride(seq_xstride), .seq_ystride(seq_ystride),
      .seq_dtsts(seq_dtsts), .seq_sub(seq_sub), .seq_sat(seq_sat),
      .seq_wb(seq_wb), .seq_dest(seq_dest),
      .mul_mv(mul_mv), .mul_mn(mul_mn),
      .seq_rf_xaddr(seq_rf_xaddr), .seq_rf_yaddr(seq_rf_yaddr),
      .seq_rf_we(seq_rf_we), .seq_rf_waddr(seq_rf_waddr),
      .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts),
      .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
      .seq_busy(seq_busy), .seq_done(seq_done),
      .seq_mv_sticky(seq_mv_sticky), .seq_mn(seq_mn)
   );

   assign obs = {ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc,
                 seq_rf_xaddr, seq_rf_yaddr, seq_rf_we, seq_rf_waddr, seq_busy, seq_done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic scramble_cfg();
      seq_len     = 6'($urandom);
      seq_xaddr   = 4'($urandom);
      seq_yaddr   = 4'($urandom);
      seq_xstride = 4'($urandom);
      seq_ystride = 4'($urandom);
      seq_dtsts   = 4'($urandom);
      seq_sub     = 1'($urandom);
      seq_sat     = 1'($urandom);
      seq_wb      = 1'($urandom);
      seq_dest    = 4'($urandom);
   endtask

   // Starts one sequence from IDLE (called at a negedge) and checks every cycle of it.
   // abort_at: trace cycle in which seq_abort is raised, or -1 for none.
   task automatic run_seq(input string name, input int n, input int x0, input int y0,
                          input int xs, input int ys, input int dt, input bit sub,
                          input bit sat, input bit wb, input int dest, input int abort_at);
      ctl_t e;
      ctl_t tr[$];
      bit   arith[$];
      ctl_t exp_c;
      int   leff;
      bit   exp_mv, exp_mn, mv, mn;
      tr.delete();
      arith.delete();
      for (int t = 0; t < n; t++) begin
         e       = '0;
         e.en    = 1'b1;
         e.otreg = 1'b1;
         e.dtsts = 4'(dt);
         e.cls   = (t == 0) ? 2'b01 : (sub ? 2'b11 : 2'b10);
         e.xa    = 4'((x0 + t * xs) % 16);
         e.ya    = 4'((y0 + t * ys) % 16);
         e.busy  = 1'b1;
         tr.push_back(e);
         arith.push_back(1'b1);
      end
      if (n > 0 && sat) begin
         e = '0; e.en = 1'b1; e.otreg = 1'b1; e.dtsts = 4'(dt); e.sc = 2'b11; e.busy = 1'b1;
         tr.push_back(e);
         arith.push_back(1'b1);
      end
      if (n > 0 && wb) begin
         e = '0; e.en = 1'b1; e.dtsts = 4'(dt); e.sc = (dt & 2) != 0 ? 2'b01 : 2'b00; e.busy = 1'b1;
         tr.push_back(e);
         arith.push_back(1'b0);
         e = '0; e.we = 1'b1; e.wa = 4'(dest); e.busy = 1'b1;
         tr.push_back(e);
         arith.push_back(1'b0);
      end
      e = '0; e.done = 1'b1;
      tr.push_back(e);
      arith.push_back(1'b0);

      leff = (abort_at >= 0 && abort_at < tr.size()) ? abort_at + 1 : tr.size();
      exp_mv = 1'b0;
      exp_mn = 1'b0;

      seq_start   = 1'b1;
      seq_abort   = 1'b0;
      seq_len     = 6'(n);
      seq_xaddr   = 4'(x0);
      seq_yaddr   = 4'(y0);
      seq_xstride = 4'(xs);
      seq_ystride = 4'(ys);
      seq_dtsts   = 4'(dt);
      seq_sub     = sub;
      seq_sat     = sat;
      seq_wb      = wb;
      seq_dest    = 4'(dest);
      @(negedge clk);
      for (int c = 0; c < leff + 2; c++) begin
         exp_c = (c < leff) ? tr[c] : ctl_t'(0);
         check_eq($sformatf("%s ctl[%0d]", name, c), 32'(obs), 32'(exp_c));
         if (c == leff + 1) begin
            check_eq($sformatf("%s mv_sticky", name), 32'(seq_mv_sticky), 32'(exp_mv));
            check_eq($sformatf("%s mn", name), 32'(seq_mn), 32'(exp_mn));
         end
         mv     = 1'($urandom);
         mn     = 1'($urandom);
         mul_mv = mv;
         mul_mn = mn;
         if (c >= 1 && c - 1 < leff && arith[c-1]) begin
            exp_mv = exp_mv | mv;
            exp_mn = mn;
         end
         // while busy, wiggle config and start: none of it may be taken
         scramble_cfg();
         seq_start = (c < leff) ? 1'($urandom) : 1'b0;
         seq_abort = (c == abort_at);
         @(negedge clk);
      end
      seq_start = 1'b0;
      seq_abort = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      seq_start = 1'b0;
      seq_abort = 1'b0;
      mul_mv    = 1'b0;
      mul_mn    = 1'b0;
      scramble_cfg();
      #2;
      check_eq("reset ctl", 32'(obs), 32'h0);
      check_eq("reset flags", 32'({seq_mv_sticky, seq_mn}), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run_seq("ssi",       3,  0, 3, 1, 1, 4'b0000, 1'b0, 1'b0, 1'b1, 9, -1);
      run_seq("uui_sub",   2,  5, 6, 1, 1, 4'b1100, 1'b1, 1'b0, 1'b0, 0, -1);
      run_seq("ssf_satwb", 2,  1, 1, 0, 0, 4'b0010, 1'b0, 1'b1, 1'b1, 4, -1);
      run_seq("wrap",      4, 14, 2, 1, 3, 4'b0001, 1'b0, 1'b0, 1'b0, 0, -1);
      run_seq("n0",        0,  3, 3, 1, 1, 4'b0000, 1'b0, 1'b1, 1'b1, 7, -1);
      run_seq("abort",     5,  0, 8, 2, 1, 4'b0000, 1'b0, 1'b0, 1'b1, 5, 1);

      for (int i = 0; i < 40; i++) begin
         int n, ab, tlen;
         bit sat, wb;
         n    = $urandom_range(0, 12);
         sat  = 1'($urandom);
         wb   = 1'($urandom);
         tlen = (n == 0) ? 1 : n + (sat ? 1 : 0) + (wb ? 2 : 0) + 1;
         ab   = ($urandom_range(0, 3) == 0 && tlen >= 2) ? $urandom_range(0, tlen - 2) : -1;
         run_seq($sformatf("rnd%0d", i), n, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 1'($urandom), sat, wb, $urandom_range(0, 15), ab);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // reset in the middle of a sequence clears everything at once
      seq_start = 1'b1;
      seq_len   = 6'd5;
      seq_wb    = 1'b1;
      seq_sat   = 1'b1;
      @(negedge clk);
      seq_start = 1'b0;
      mul_mv    = 1'b1;
      mul_mn    = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("pre-reset busy", 32'(seq_busy), 32'h1);
      reset = 1'b0;
      #1;
      check_eq("midseq reset ctl", 32'(obs), 32'h0);
      check_eq("midseq reset flags", 32'({seq_mv_sticky, seq_mn}), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("post-reset idle", 32'(obs), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
